sdm_recall_controller: RTL
==========================

SDM_RECALL_CONTROLLER -- requirements
Module: sdm_recall_controller

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 512: width of address and data words.
REQ-002 SHALL have parameter MAX_ITER, default 4: maximum recall passes per read request.
REQ-003 SHALL have parameter ITER_WIDTH, default 3: width of the pass counter, which SHALL hold MAX_ITER.
REQ-004 SHALL have parameter TIMEOUT, default 15: cycles waited for sdmReadValid before abort.
REQ-005 SHALL have parameter TIMER_WIDTH, default 4: width of the wait timer, which SHALL hold TIMEOUT.
REQ-006 SHALL use a single clock and an asynchronous, active-low reset.
REQ-007 Ports, as name / direction / width / meaning:
- clk  input  1  clock; all state changes on rising edge.
- rstb  input  1  asynchronous active-low reset.
- reqValid  input  1  host request present.
- reqReady  output  1  controller accepts a request.
- reqAddress  input  BIT_WIDTH  query or training word.
- reqWnr  input  1  1 = write/train, 0 = read/recall.
- sdmAddress  output  BIT_WIDTH  word driven to the memory.
- sdmValid  output  1  one-cycle memory access strobe.
- sdmWnr  output  1  memory access type.
- sdmReadValid  input  1  memory decision available.
- sdmReadSuccess  input  1  memory found a unique, valid location.
- sdmData  input  BIT_WIDTH  memory read data.
- rspValid  output  1  response present.
- rspReady  input  1  host accepts the response.
- rspSuccess, rspConverged, rspTimeout  output  1 each  result flags.
- rspData  output  BIT_WIDTH  final recalled word.
- rspIterations  output  ITER_WIDTH  passes issued.

Function
REQ-008 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-009 IDLE: reqReady=1; on reqValid, SHALL latch reqAddress into curAddr, latch reqWnr, clear iter, and go to ISSUE; the handshake SHALL complete in the same cycle.
REQ-010 ISSUE: for exactly one cycle SHALL drive sdmValid=1, sdmAddress=curAddr and sdmWnr=latched wnr; SHALL increment iter, clear the timer, and go to WAIT.
REQ-011 WAIT: the timer SHALL increment each cycle without sdmReadValid; sdmValid=0.
REQ-012 In WAIT with sdmReadValid and wnr=1, SHALL go to RESP with rspSuccess=sdmReadSuccess, rspConverged=0 and rspData=curAddr.
REQ-013 In WAIT with sdmReadValid, wnr=0 and sdmReadSuccess=0, SHALL go to RESP with rspSuccess=0 and rspData=curAddr.
REQ-014 In WAIT with sdmReadValid, wnr=0, sdmReadSuccess=1 and sdmData==curAddr, SHALL go to RESP with rspSuccess=1, rspConverged=1 and rspData=sdmData.
REQ-015 In WAIT with sdmReadValid, wnr=0, sdmReadSuccess=1, sdmData!=curAddr and iter==MAX_ITER, SHALL go to RESP with rspSuccess=1, rspConverged=0 and rspData=sdmData.
REQ-016 In WAIT otherwise on a successful, non-converged read, SHALL load curAddr with sdmData and return to ISSUE (iterative recall).
REQ-017 In WAIT, if the timer equals TIMEOUT with no sdmReadValid, SHALL go to RESP with rspTimeout=1, rspSuccess=0 and rspData=curAddr.
REQ-018 If sdmReadValid and the timeout coincide in the same cycle, sdmReadValid SHALL win.
REQ-019 RESP: rspValid=1, and all rsp* outputs SHALL be held stable until rspReady; on rspReady SHALL return to IDLE; the next request SHALL be accepted no earlier than the following cycle.
REQ-020 rspIterations SHALL equal iter at RESP entry (1..MAX_ITER).
REQ-021 sdmReadValid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-022 reqReady SHALL be 0 in every state except IDLE.
REQ-023 All outputs SHALL be registered, except reqReady, which SHALL decode from state.

Reset
REQ-024 On rstb=0, SHALL enter IDLE asynchronously and clear all registers, including curAddr, iter, timer and all sdm*/rsp* outputs, to 0.
REQ-025 After reset release, SHALL drive reqReady=1.
REQ-026 Reset mid-operation SHALL abort the transaction without issuing a response.

Structure
REQ-027 The package sdm_ctrl_pkg SHALL hold the state encoding and the default values of MAX_ITER and TIMEOUT.
REQ-028 The wait timer (clear, increment, expiry compare) SHALL be the sub-module sdm_wait_timer.

Verification
REQ-029 The bench SHALL use BIT_WIDTH=16, and SHALL cover:
- Read 0x00F0; memory returns success with data 0x00F0 after 2 cycles -> rspSuccess=1, rspConverged=1, rspData=0x00F0, rspIterations=1.
- Read 0x0001; memory returns 0x0003, then 0x0007, then 0x0007 -> three sdmValid pulses, rspConverged=1, rspData=0x0007, rspIterations=3.
- Read with every pass returning a new word -> exactly 4 sdmValid pulses, rspSuccess=1, rspConverged=0, rspIterations=4.
- Write 0xBEEF; memory never asserts sdmReadValid -> rspTimeout=1 after 15 wait cycles; sdmReadValid arriving on the 15th wait cycle instead -> rspTimeout=0.
- rspReady held low for 5 cycles -> rsp* stable and reqReady=0; rstb pulsed in WAIT -> IDLE, rspValid=0, reqReady=1 after release.

Source files
------------

// File: rtl/sdm_ctrl_pkg.sv
// Shared definitions for the SDM recall controller: state encoding and
// default pass/timeout limits.
package sdm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ctrlStateT;

    localparam int MAX_ITER_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT  = 15;

endpackage

// File: rtl/sdm_wait_timer.sv
// Counts WAIT cycles without a memory decision; expired flags the cycle whose
// increment would bring the count up to TIMEOUT.
module sdm_wait_timer
    import sdm_ctrl_pkg::*;
#(
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int TIMER_WIDTH = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [TIMER_WIDTH-1:0] count;
    logic [TIMER_WIDTH-1:0] countNext;

    assign countNext = count + 1'b1;
    assign expired   = inc && (countNext == TIMER_WIDTH'(TIMEOUT));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/sdm_recall_controller.sv
// Iterative recall controller for a sparse distributed memory: a read feeds
// each returned word back as the next query until it converges or runs out.
//
// state | meaning
// IDLE  | ready for a host request
// ISSUE | one-cycle memory access strobe
// WAIT  | waiting for the memory decision or timeout
// RESP  | response held until the host takes it
module sdm_recall_controller
    import sdm_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH   = 512,
    parameter int MAX_ITER    = MAX_ITER_DEFAULT,
    parameter int ITER_WIDTH  = 3,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int TIMER_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [BIT_WIDTH-1:0]  reqAddress,
    input  logic                  reqWnr,
    output logic [BIT_WIDTH-1:0]  sdmAddress,
    output logic                  sdmValid,
    output logic                  sdmWnr,
    input  logic                  sdmReadValid,
    input  logic                  sdmReadSuccess,
    input  logic [BIT_WIDTH-1:0]  sdmData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic                  rspSuccess,
    output logic                  rspConverged,
    output logic                  rspTimeout,
    output logic [BIT_WIDTH-1:0]  rspData,
    output logic [ITER_WIDTH-1:0] rspIterations
);

    ctrlStateT             state;
    logic [BIT_WIDTH-1:0]  curAddr;
    logic                  wnr;
    logic [ITER_WIDTH-1:0] iter;
    logic                  timerExpired;

    logic                  doneNow;
    logic                  reload;
    logic                  resSuccess;
    logic                  resConverged;
    logic                  resTimeout;
    logic [BIT_WIDTH-1:0]  resData;

    assign reqReady = (state == IDLE);

    sdm_wait_timer #(
        .TIMEOUT     (TIMEOUT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) uWaitTimer (
        .clk     (clk),
        .rstb    (rstb),
        .clear   (state == ISSUE),
        .inc     ((state == WAIT) && !sdmReadValid),
        .expired (timerExpired)
    );

    // A memory decision always takes priority over a coincident timeout.
    always_comb begin
        doneNow      = 1'b0;
        reload       = 1'b0;
        resSuccess   = 1'b0;
        resConverged = 1'b0;
        resTimeout   = 1'b0;
        resData      = curAddr;
        if (state == WAIT) begin
            if (sdmReadValid) begin
                if (wnr) begin
                    doneNow    = 1'b1;
                    resSuccess = sdmReadSuccess;
                end else if (!sdmReadSuccess) begin
                    doneNow = 1'b1;
                end else if (sdmData == curAddr) begin
                    doneNow      = 1'b1;
                    resSuccess   = 1'b1;
                    resConverged = 1'b1;
                    resData      = sdmData;
                end else if (iter == ITER_WIDTH'(MAX_ITER)) begin
                    doneNow    = 1'b1;
                    resSuccess = 1'b1;
                    resData    = sdmData;
                end else begin
                    reload = 1'b1;
                end
            end else if (timerExpired) begin
                doneNow    = 1'b1;
                resTimeout = 1'b1;
            end
        end
    end

    // sdmValid is raised on entry to ISSUE so the registered strobe lines up
    // with the single ISSUE cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            curAddr       <= '0;
            wnr           <= 1'b0;
            iter          <= '0;
            sdmAddress    <= '0;
            sdmValid      <= 1'b0;
            sdmWnr        <= 1'b0;
            rspValid      <= 1'b0;
            rspSuccess    <= 1'b0;
            rspConverged  <= 1'b0;
            rspTimeout    <= 1'b0;
            rspData       <= '0;
            rspIterations <= '0;
        end else begin
            sdmValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        curAddr    <= reqAddress;
                        wnr        <= reqWnr;
                        iter       <= '0;
                        sdmAddress <= reqAddress;
                        sdmWnr     <= reqWnr;
                        sdmValid   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    iter  <= iter + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (reload) begin
                        curAddr    <= sdmData;
                        sdmAddress <= sdmData;
                        sdmValid   <= 1'b1;
                        state      <= ISSUE;
                    end else if (doneNow) begin
                        rspValid      <= 1'b1;
                        rspSuccess    <= resSuccess;
                        rspConverged  <= resConverged;
                        rspTimeout    <= resTimeout;
                        rspData       <= resData;
                        rspIterations <= iter;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
